// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared types and constants for the vector load/store path
package vec_pkg;

    localparam int VLEN_MAX = 16;
    localparam int LANES    = 4;
    localparam int DW       = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } vload_state_t;

    typedef logic [31:0] elem_t;

endpackage

// File: rtl/vload_addr_gen.sv
// rtl/vload_addr_gen.sv - four-lane strided address generator, purely combinational
module vload_addr_gen
    import vec_pkg::*;
(
    input  elem_t              ptr,
    input  elem_t              stride,
    output elem_t [LANES-1:0]  lane_addr,
    output elem_t              next_ptr
);

    // Lane offsets use shift/add so no multiplier is inferred; all sums wrap modulo 2^32.
    always_comb begin
        lane_addr[0] = ptr;
        lane_addr[1] = ptr + stride;
        lane_addr[2] = ptr + (stride << 1);
        lane_addr[3] = ptr + (stride << 1) + stride;
        next_ptr     = ptr + (stride << 2);
    end

endmodule

// File: rtl/vector_load_unit.sv
// rtl/vector_load_unit.sv - strided vector load sequencer feeding one vector register
module vector_load_unit #(
    parameter int VLEN_MAX = 16,
    parameter int LANES    = 4,
    parameter int DW       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DW-1:0]          base_addr,
    input  logic [DW-1:0]          stride,
    input  logic [4:0]             vlen,
    output logic                   busy,
    output logic [DW-1:0]          addr1,
    output logic [DW-1:0]          addr2,
    output logic [DW-1:0]          addr3,
    output logic [DW-1:0]          addr4,
    input  logic [DW-1:0]          rdata1,
    input  logic [DW-1:0]          rdata2,
    input  logic [DW-1:0]          rdata3,
    input  logic [DW-1:0]          rdata4,
    output logic [VLEN_MAX*DW-1:0] result,
    output logic [VLEN_MAX-1:0]    wr_mask,
    output logic                   wr_en,
    output logic                   done
);
    import vec_pkg::*;

    // idx must hold idx+LANES past the last beat without overflowing
    localparam int IW = $clog2(VLEN_MAX + LANES) + 1;
    localparam int EW = $clog2(VLEN_MAX);

    vload_state_t                  state, state_d;
    logic [DW-1:0]                 ptr, stride_q;
    logic [IW-1:0]                 idx, vlen_q, vlen_sat;
    logic [VLEN_MAX-1:0][DW-1:0]   res_q;
    logic [VLEN_MAX-1:0]           mask_q;
    logic [LANES-1:0]              active;
    logic [LANES-1:0][IW-1:0]      lane_idx;
    logic [LANES-1:0][DW-1:0]      rd;
    elem_t [3:0]                   lane_addr;
    elem_t                         next_ptr;

    assign rd       = {rdata4, rdata3, rdata2, rdata1};
    assign vlen_sat = (IW'(vlen) > IW'(VLEN_MAX)) ? IW'(VLEN_MAX) : IW'(vlen);
    assign result   = res_q;
    assign wr_mask  = mask_q;

    vload_addr_gen u_addr_gen (
        .ptr       (ptr),
        .stride    (stride_q),
        .lane_addr (lane_addr),
        .next_ptr  (next_ptr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state, lane activity and outputs; addresses depend only on registered state
    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        wr_en   = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane_idx[k] = idx + IW'(k);
            active[k]   = (state == ISSUE) && (lane_idx[k] < vlen_q);
        end
        addr1 = active[0] ? lane_addr[0] : '0;
        addr2 = active[1] ? lane_addr[1] : '0;
        addr3 = active[2] ? lane_addr[2] : '0;
        addr4 = active[3] ? lane_addr[3] : '0;
        case (state)
            IDLE: begin
                if (start) state_d = (vlen_sat == '0) ? DONE : ISSUE;
            end
            ISSUE: begin
                busy = 1'b1;
                if (idx + IW'(LANES) >= vlen_q) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                wr_en   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request capture, beat pointer/index advance and element/mask capture
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            stride_q <= '0;
            idx      <= '0;
            vlen_q   <= '0;
            res_q    <= '0;
            mask_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr      <= base_addr;
                        stride_q <= stride;
                        vlen_q   <= vlen_sat;
                        idx      <= '0;
                        res_q    <= '0;
                        mask_q   <= '0;
                    end
                end
                ISSUE: begin
                    for (int k = 0; k < LANES; k++) begin
                        if (active[k]) begin
                            res_q[lane_idx[k][EW-1:0]]  <= rd[k];
                            mask_q[lane_idx[k][EW-1:0]] <= 1'b1;
                        end
                    end
                    ptr <= next_ptr;
                    idx <= idx + IW'(LANES);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_load_unit.sv
// tb/tb_vector_load_unit.sv - randomized self-checking bench for vector_load_unit
module tb_vector_load_unit;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  base_addr, stride;
    logic [4:0]   vlen;
    logic         busy, wr_en, done;
    logic [31:0]  addr1, addr2, addr3, addr4;
    logic [31:0]  rdata1, rdata2, rdata3, rdata4;
    logic [511:0] result;
    logic [15:0]  wr_mask;
    logic [31:0]  a_obs [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Memory image: RAM[a] = 0x1000 + a, combinational read
    assign rdata1 = 32'h1000 + addr1;
    assign rdata2 = 32'h1000 + addr2;
    assign rdata3 = 32'h1000 + addr3;
    assign rdata4 = 32'h1000 + addr4;
    assign a_obs[0] = addr1;
    assign a_obs[1] = addr2;
    assign a_obs[2] = addr3;
    assign a_obs[3] = addr4;

    vector_load_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .vlen      (vlen),
        .busy      (busy),
        .addr1     (addr1),
        .addr2     (addr2),
        .addr3     (addr3),
        .addr4     (addr4),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .rdata3    (rdata3),
        .rdata4    (rdata4),
        .result    (result),
        .wr_mask   (wr_mask),
        .wr_en     (wr_en),
        .done      (done)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " wr_en"}, wr_en, 0);
        check({tag, " result"}, result, 0);
        check({tag, " wr_mask"}, wr_mask, 0);
        for (int k = 0; k < 4; k++) check($sformatf("%s addr%0d", tag, k + 1), a_obs[k], 0);
    endtask

    // Runs one load and checks every cycle against element-level arithmetic
    task automatic do_load(input logic [31:0] b, input logic [31:0] s, input logic [4:0] v);
        int           vl, nb, e;
        logic [511:0] er;
        logic [15:0]  em;
        logic [31:0]  ea;
        vl = (v > 16) ? 16 : int'(v);
        nb = (vl + 3) / 4;
        er = '0;
        em = '0;
        for (int i = 0; i < vl; i++) begin
            er[32*i +: 32] = 32'h1000 + b + 32'(i) * s;
            em[i] = 1'b1;
        end
        @(negedge clk);
        base_addr = b; stride = s; vlen = v; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= nb + 1; c++) begin
            @(negedge clk);
            check($sformatf("busy c%0d", c), busy, 1);
            if (c <= nb) begin
                check($sformatf("done early c%0d", c), done, 0);
                for (int k = 0; k < 4; k++) begin
                    e  = 4 * (c - 1) + k;
                    ea = (e < vl) ? b + 32'(e) * s : 32'h0;
                    check($sformatf("addr%0d c%0d b=%0h s=%0h v=%0d", k + 1, c, b, s, v), a_obs[k], ea);
                end
            end else begin
                check($sformatf("done v=%0d", v), done, 1);
                check($sformatf("wr_en v=%0d", v), wr_en, 1);
                check($sformatf("result b=%0h s=%0h v=%0d", b, s, v), result, er);
                check($sformatf("wr_mask v=%0d", v), wr_mask, em);
            end
        end
        @(negedge clk);
        check("busy after", busy, 0);
        check("done after", done, 0);
        check("wr_en after", wr_en, 0);
        check("result hold", result, er);
        check("wr_mask hold", wr_mask, em);
    endtask

    // Holds start high through edge `drop_edge`, returns done count and first/last cycle
    task automatic held_start(input int drop_edge, output int dones, output int first, output int last);
        dones = 0; first = -1; last = -1;
        @(negedge clk);
        base_addr = 32'h40; stride = 32'h2; vlen = 5'd8; start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            if (c == drop_edge) #1 start = 1'b0;
            @(negedge clk);
            if (done) begin
                dones++;
                if (first < 0) first = c + 1;
                last = c + 1;
            end
        end
    endtask

    initial begin
        int d, f, l, rv;
        logic [31:0] rb, rs;
        rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; vlen = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        do_load(32'h10, 32'h1, 5'd16);
        do_load(32'h0, 32'h3, 5'd5);
        do_load(32'h55, 32'h7, 5'd0);
        do_load(32'h10, 32'h1, 5'd20);
        do_load(32'h20, 32'hFFFF_FFFF, 5'd4);
        do_load(32'hFFFF_FFFE, 32'h1, 5'd7);

        for (int t = 0; t < 40; t++) begin
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: rs = 32'($urandom_range(0, 8));
                1: rs = -32'($urandom_range(1, 8));
                default: rs = $urandom;
            endcase
            rv = $urandom_range(0, 31);
            do_load(rb, rs, 5'(rv));
        end

        held_start(3, d, f, l);
        check("held start done count", 32'(d), 1);
        check("held start done cycle", 32'(f), 3);
        held_start(4, d, f, l);
        check("restart done count", 32'(d), 2);
        check("restart second done cycle", 32'(l), 7);

        @(negedge clk);
        base_addr = 32'h10; stride = 32'h1; vlen = 5'd16; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero("mid reset");
        rst = 1'b0;
        d = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || wr_en) d++;
        end
        check("aborted load pulses", 32'(d), 0);
        check("post abort busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vector_load_unit.md
# vector_load_unit

Sequences a strided vector load from the 4-read-port data memory into one vector register. Given a base word address, stride and element count, it drives the memory's four address ports with four consecutive strided addresses per cycle, captures the four returned words, and packs them into a 16-element result. When the result is complete it presents it with a one-cycle write strobe and mask to the vector register file. It sits between the decode/issue stage and the data memory.

## Interface
Parameters:
- VLEN_MAX, 16: elements per vector register. Must be a multiple of LANES.
- LANES, 4: memory read ports used per beat. Fixed to match the data memory.
- DW, 32: element and address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  load request, sampled only in IDLE
- base_addr  in  32  word address of element 0
- stride  in  32  word stride, two's complement
- vlen  in  5  element count; 0..16, values >16 saturate to 16
- busy  out  1  high in every non-IDLE state
- addr1..addr4  out  32 each  to memory read ports, lane 0..3
- rdata1..rdata4  in  32 each  from memory, combinational, same cycle
- result  out  VLEN_MAX*32  element i in bits [32i+31:32i]
- wr_mask  out  16  bit i set when element i was loaded
- wr_en  out  1  one-cycle register-file write strobe
- done  out  1  one-cycle completion pulse, coincident with wr_en

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: when start=1, capture base_addr, stride and saturated vlen. Clear result and wr_mask. Set ptr=base_addr and idx=0.
  - vlen=0: go to DONE.
  - otherwise: go to ISSUE.
- ISSUE, one beat per cycle:
  - lane k drives addr(k+1) = ptr + k*stride, modulo 2^32. Use k*stride = 0, s, s<<1, (s<<1)+s.
  - lane k is active iff idx+k < vlen. Inactive lanes drive address 0.
  - at the clock edge, for each active lane: result[idx+k] <= rdata(k+1) and wr_mask[idx+k] <= 1.
  - then ptr <= ptr + (stride<<2) and idx <= idx+4.
  - when idx+4 >= vlen, go to DONE.
- DONE: assert done=1 and wr_en=1 for exactly one cycle, then go to IDLE.
- result and wr_mask hold their values until the next accepted start or reset.
- start in ISSUE or DONE is ignored; it is neither queued nor latched.
- No range check is made on addresses. Address wrap-around past 2^32 is plain modulo arithmetic. Keeping addresses inside the memory depth is software's job.
- Reset mid-operation: the next state is IDLE. done and wr_en are never asserted for the aborted load.
- Reset values: state=IDLE, busy=0, done=0, wr_en=0, addr1..4=0, result=0, wr_mask=0, ptr=0, idx=0.

## Timing
- Cycle 0: start sampled high in IDLE.
- Beat n (n=0..B-1) occupies cycle n+1, where B=ceil(vlen/4). busy is high from cycle 1.
- Cycle B+1: DONE, with done=wr_en=1 and result valid.
- Cycle B+2: IDLE, busy=0. The earliest next start is sampled here.
- Total latency from start to done is B+1 cycles: 5 for vlen=16, 2 for vlen 1..4, 1 for vlen=0.
- Addresses are registered-state driven: they are a function of ptr only, with no combinational path from start or base_addr.
- Read data is combinational from memory and is captured on the same edge that ends the beat.

## Structure
- Shared package vec_pkg holds:
  - VLEN_MAX, LANES, DW;
  - the enum vload_state_t {IDLE, ISSUE, DONE};
  - the element type elem_t (logic [31:0]).
- One sub-module, vload_addr_gen. Its inputs are ptr and stride; its outputs are the four lane addresses and the next ptr. It is purely combinational and reusable by a future vector store unit.
- The FSM, the idx counter and the result/mask registers live in the top.

## Test plan
- Memory preloaded with RAM[i]=0x1000+i. Start with base=0x10, stride=1, vlen=16 -> addresses 0x10..0x13 in cycle 1 and 0x1C..0x1F in cycle 4; done in cycle 5; result[i]=0x1010+i; wr_mask=0xFFFF.
- base=0x0, stride=3, vlen=5 -> beat 0 addresses 0,3,6,9; beat 1 addresses 12,0,0,0; done in cycle 3; wr_mask=0x001F; elements 5..15 equal 0.
- vlen=0 -> done and wr_en in cycle 1, wr_mask=0, result=0, no ISSUE cycle. vlen=20 -> behaves exactly as vlen=16.
- base=0x20, stride=0xFFFFFFFF, vlen=4 -> addresses 0x20,0x1F,0x1E,0x1D; done in cycle 2.
- Start while busy, held high through a vlen=8 load -> exactly one done; the second load starts only from the cycle-after-DONE sample.
- rst asserted in cycle 2 of a vlen=16 load -> IDLE next cycle; busy, done, wr_en, result, wr_mask and addr1..4 all 0; no done pulse for the aborted load.
